// File: rtl/fproc_arb_pkg.sv
// Shared types and helpers for the fproc arbiter.
package fproc_arb_pkg;

  typedef enum logic {StIdle, StWait} state_e;

  // Upper bound on core count supported by next_rr.
  localparam int unsigned MaxCores = 32;

  // First set bit of pending strictly after last, wrapping modulo n.
  // If nothing is pending, returns last unchanged.
  function automatic int unsigned next_rr(input logic [MaxCores-1:0] pending,
                                          input int unsigned last,
                                          input int unsigned n);
    int unsigned res;
    int unsigned idx;
    logic found;
    res   = last;
    found = 1'b0;
    for (int unsigned k = 1; k <= MaxCores; k++) begin
      idx = (last + k) % n;
      if (!found && (k <= n) && pending[idx[4:0]]) begin
        found = 1'b1;
        res   = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority select over the pending vector.
module rr_pick import fproc_arb_pkg::*; #(
  parameter int unsigned N_CORES = 4,
  localparam int unsigned CoreW = $clog2(N_CORES)
) (
  input  logic [N_CORES-1:0] pending_i,
  input  logic [CoreW-1:0]   last_i,
  output logic [CoreW-1:0]   grant_o,
  output logic               any_o
);

  logic [MaxCores-1:0] pend_ext;
  int unsigned         pick;

  // Pick the first pending core after the last one served.
  always_comb begin
    pend_ext                = '0;
    pend_ext[N_CORES-1:0]   = pending_i;
    pick                    = next_rr(pend_ext, 32'(last_i), N_CORES);
    grant_o                 = CoreW'(pick);
    any_o                   = |pending_i;
  end

endmodule

// File: rtl/fproc_arbiter.sv
// Shares one function processor between N_CORES cores: latches one-cycle requests,
// issues them round-robin, and routes each result (or a timeout) back to its core.
module fproc_arbiter import fproc_arb_pkg::*; #(
  parameter int unsigned N_CORES            = 4,
  parameter int unsigned FPROC_ID_WIDTH     = 8,
  parameter int unsigned FPROC_RESULT_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [N_CORES-1:0]                      core_enable,
  input  logic [N_CORES*FPROC_ID_WIDTH-1:0]       core_id,
  output logic [N_CORES-1:0]                      core_ready,
  output logic [N_CORES*FPROC_RESULT_WIDTH-1:0]   core_data,
  output logic                                    fp_enable,
  output logic [FPROC_ID_WIDTH-1:0]               fp_id,
  output logic [$clog2(N_CORES)-1:0]              fp_core,
  input  logic                                    fp_ready,
  input  logic [FPROC_RESULT_WIDTH-1:0]           fp_data,
  output logic                                    timeout_err,
  output logic                                    dup_err
);

  localparam int unsigned CoreW = $clog2(N_CORES);
  localparam int unsigned CntW  = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast =
      CntW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_e                                           state_q, state_d;
  logic [N_CORES-1:0]                               pending_q, pending_d;
  logic [N_CORES-1:0]                               clr, pend_eff, accept, dup_vec;
  logic [N_CORES-1:0][FPROC_ID_WIDTH-1:0]           id_q, id_d, core_id_arr;
  logic [CoreW-1:0]                                 grant_q, grant_d, last_q, last_d, pick;
  logic                                             any_pending;
  logic [CntW-1:0]                                  cnt_q, cnt_d;
  logic                                             fp_enable_q, fp_enable_d;
  logic [FPROC_ID_WIDTH-1:0]                        fp_id_q, fp_id_d;
  logic [N_CORES-1:0]                               core_ready_q, core_ready_d;
  logic [N_CORES-1:0][FPROC_RESULT_WIDTH-1:0]       core_data_q, core_data_d;
  logic                                             terr_q, terr_d, dup_q, dup_d;
  logic                                             timeout_hit;

  assign core_id_arr = core_id;

  rr_pick #(
    .N_CORES (N_CORES)
  ) u_rr_pick (
    .pending_i (pending_q),
    .last_i    (last_q),
    .grant_o   (pick),
    .any_o     (any_pending)
  );

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CntLast) && !fp_ready;

  // FSM next state: issue from IDLE, complete or time out from WAIT.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    fp_enable_d  = 1'b0;
    fp_id_d      = fp_id_q;
    core_ready_d = '0;
    core_data_d  = core_data_q;
    terr_d       = terr_q;
    clr          = '0;
    unique case (state_q)
      StIdle: begin
        if (any_pending) begin
          fp_enable_d = 1'b1;
          fp_id_d     = id_q[pick];
          grant_d     = pick;
          cnt_d       = '0;
          state_d     = StWait;
        end
      end
      StWait: begin
        if (cnt_q != {CntW{1'b1}}) cnt_d = cnt_q + CntW'(1);
        if (fp_ready || timeout_hit) begin
          core_ready_d[grant_q] = 1'b1;
          core_data_d[grant_q]  = fp_ready ? fp_data : '1;
          clr[grant_q]          = 1'b1;
          last_d                = grant_q;
          state_d               = StIdle;
          if (!fp_ready) terr_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Request capture: a bit being cleared this edge may be re-set (set wins).
  always_comb begin
    pend_eff  = pending_q & ~clr;
    accept    = core_enable & ~pend_eff;
    dup_vec   = core_enable & pend_eff;
    pending_d = pend_eff | accept;
    id_d      = id_q;
    for (int i = 0; i < int'(N_CORES); i++) begin
      if (accept[i]) id_d[i] = core_id_arr[i];
    end
    dup_d = dup_q | (|dup_vec);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      pending_q    <= '0;
      id_q         <= '0;
      grant_q      <= '0;
      last_q       <= CoreW'(N_CORES - 1);
      cnt_q        <= '0;
      fp_enable_q  <= 1'b0;
      fp_id_q      <= '0;
      core_ready_q <= '0;
      core_data_q  <= '0;
      terr_q       <= 1'b0;
      dup_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      id_q         <= id_d;
      grant_q      <= grant_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      fp_enable_q  <= fp_enable_d;
      fp_id_q      <= fp_id_d;
      core_ready_q <= core_ready_d;
      core_data_q  <= core_data_d;
      terr_q       <= terr_d;
      dup_q        <= dup_d;
    end
  end

  assign fp_enable   = fp_enable_q;
  assign fp_id       = fp_id_q;
  assign fp_core     = grant_q;
  assign core_ready  = core_ready_q;
  assign core_data   = core_data_q;
  assign timeout_err = terr_q;
  assign dup_err     = dup_q;

endmodule
